// File: rtl/dm_arb_pkg.sv
// ---------------------------------------------------------------------------
// dm_arb_pkg -- shared definitions for the two-port data-memory arbiter.
//
// Contents:
//   DEF_ADDR_W / DEF_DATA_W / DEF_MAX_BURST : parameter defaults
//   CNT_W                                   : burst counter width (MAX_BURST <= 15)
//   state_t                                 : arbiter state (IDLE, OWN0, OWN1)
// ---------------------------------------------------------------------------
package dm_arb_pkg;

    localparam int DEF_ADDR_W    = 16;
    localparam int DEF_DATA_W    = 16;
    localparam int DEF_MAX_BURST = 4;
    localparam int CNT_W         = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

endpackage

// File: rtl/dm_arbiter_if.sv
// ---------------------------------------------------------------------------
// dm_arbiter_if -- bundle of every signal between the arbiter, its two
// requesters and the data memory.
//
//   Requester side : reqX, weX, addrX, wdataX (in), gntX, rvalidX, rd_data (out)
//   Memory side    : mem_addr, mem_wdata, mem_re, mem_we (out), mem_rdata (in)
//
// Modports:
//   slave  : the arbiter
//   master : the environment (both requesters plus the memory)
// ---------------------------------------------------------------------------
interface dm_arbiter_if
    import dm_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;

    logic              gnt0;
    logic              gnt1;
    logic              rvalid0;
    logic              rvalid1;
    logic [DATA_W-1:0] rd_data;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_re;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_rdata,
        output gnt0, gnt1, rvalid0, rvalid1, rd_data,
        output mem_addr, mem_wdata, mem_re, mem_we
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1, rd_data,
        input  mem_addr, mem_wdata, mem_re, mem_we
    );

endinterface

// File: rtl/dm_arb_pick.sv
// ---------------------------------------------------------------------------
// dm_arb_pick -- combinational winner selection for dm_arbiter.
//
// Ports:
//   req0, req1  : pending requests
//   state       : current owner (fairness build only)
//   burst_cnt   : consecutive grants to the current owner (fairness build only)
//   last_owner  : port granted most recently (fairness build only)
//   valid       : some port wins this cycle
//   sel         : winning port (0/1), meaningful only when valid
//
// Macro DM_ARB_FAIRNESS_EN selects burst-limited round robin; without it
// port 0 has fixed priority.
// ---------------------------------------------------------------------------
module dm_arb_pick
    import dm_arb_pkg::*;
#(
    parameter int MAX_BURST = DEF_MAX_BURST
)(
    input  logic             req0,
    input  logic             req1,
`ifdef DM_ARB_FAIRNESS_EN
    input  state_t           state,
    input  logic [CNT_W-1:0] burst_cnt,
    input  logic             last_owner,
`endif
    output logic             valid,
    output logic             sel
);

    assign valid = req0 | req1;

`ifdef DM_ARB_FAIRNESS_EN
    logic at_limit;
    assign at_limit = (burst_cnt >= CNT_W'(MAX_BURST));

    always_comb begin
        sel = 1'b0;
        if (req0 && req1) begin
            // Contention: owner keeps the bus until its burst is used up;
            // from IDLE the port served least recently goes first.
            unique case (state)
                OWN0:    sel = at_limit;
                OWN1:    sel = ~at_limit;
                default: sel = ~last_owner;
            endcase
        end else begin
            sel = req1;
        end
    end
`else
    assign sel = ~req0;
`endif

endmodule

// File: rtl/dm_arbiter.sv
// ---------------------------------------------------------------------------
// dm_arbiter -- two-port arbiter in front of a single-ported data memory.
//
// Ports:
//   clk  : clock, all state on the rising edge
//   rst  : asynchronous active-high reset
//   bus  : dm_arbiter_if.slave (requester ports, read return, memory side)
//
// One access is issued per cycle. The winner chosen at an edge drives the
// registered mem_* outputs and sees gntX for the following cycle; reads
// return on rd_data (straight from mem_rdata) in that same cycle.
//
// Build option: define DM_ARB_FAIRNESS_EN for burst-limited fair arbitration
// (MAX_BURST consecutive grants under contention); otherwise port 0 has
// fixed priority and MAX_BURST is ignored.
// ---------------------------------------------------------------------------
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_BURST = DEF_MAX_BURST
)(
    input  logic         clk,
    input  logic         rst,
    dm_arbiter_if.slave  bus
);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
    logic              mem_re_reg, mem_re_next;
    logic              mem_we_reg, mem_we_next;
    logic              pick_valid;
    logic              pick_sel;
    logic              we_sel;
    logic              gnt0, gnt1;

`ifdef DM_ARB_FAIRNESS_EN
    logic [CNT_W-1:0]  burst_cnt_reg, burst_cnt_next;
    logic              last_owner_reg, last_owner_next;
`endif

    dm_arb_pick #(
        .MAX_BURST (MAX_BURST)
    ) u_pick (
        .req0       (bus.req0),
        .req1       (bus.req1),
`ifdef DM_ARB_FAIRNESS_EN
        .state      (state_reg),
        .burst_cnt  (burst_cnt_reg),
        .last_owner (last_owner_reg),
`endif
        .valid      (pick_valid),
        .sel        (pick_sel)
    );

    // Next state and the access to issue at the coming edge.
    always_comb begin
        state_next     = IDLE;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        mem_re_next    = 1'b0;
        mem_we_next    = 1'b0;
        we_sel         = pick_sel ? bus.we1 : bus.we0;
        if (pick_valid) begin
            state_next     = pick_sel ? OWN1 : OWN0;
            mem_addr_next  = pick_sel ? bus.addr1 : bus.addr0;
            mem_wdata_next = pick_sel ? bus.wdata1 : bus.wdata0;
            mem_we_next    = we_sel;
            mem_re_next    = ~we_sel;
        end
    end

`ifdef DM_ARB_FAIRNESS_EN
    always_comb begin
        burst_cnt_next  = '0;
        last_owner_next = last_owner_reg;
        if (pick_valid) begin
            last_owner_next = pick_sel;
            // Same owner as last cycle extends the burst; a new owner
            // (or a grant out of IDLE) starts it at one.
            if (state_next == state_reg) begin
                burst_cnt_next = (burst_cnt_reg >= CNT_W'(MAX_BURST)) ?
                                 burst_cnt_reg : burst_cnt_reg + CNT_W'(1);
            end else begin
                burst_cnt_next = CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            burst_cnt_reg  <= '0;
            last_owner_reg <= 1'b1;
        end else begin
            burst_cnt_reg  <= burst_cnt_next;
            last_owner_reg <= last_owner_next;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_re_reg    <= 1'b0;
            mem_we_reg    <= 1'b0;
        end else begin
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            mem_re_reg    <= mem_re_next;
            mem_we_reg    <= mem_we_next;
        end
    end

    // The OWN states hold exactly during the cycle after a grant, so the
    // grant strobes decode straight from the state register.
    assign gnt0 = (state_reg == OWN0);
    assign gnt1 = (state_reg == OWN1);

    assign bus.gnt0      = gnt0;
    assign bus.gnt1      = gnt1;
    assign bus.rvalid0   = gnt0 & mem_re_reg;
    assign bus.rvalid1   = gnt1 & mem_re_reg;
    assign bus.rd_data   = bus.mem_rdata;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_wdata = mem_wdata_reg;
    assign bus.mem_re    = mem_re_reg;
    assign bus.mem_we    = mem_we_reg;

endmodule

// File: tb/tb_dm_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dm_arbiter -- self-checking bench for dm_arbiter.
// A behavioural memory answers on the falling edge. Expected grants come from
// a grant-history model (streak length and last served port), expected read
// data from a shadow copy of memory written in grant order.
// Honours DM_ARB_FAIRNESS_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_dm_arbiter;
    import dm_arb_pkg::*;

    localparam int AW = DEF_ADDR_W;
    localparam int DW = DEF_DATA_W;
    localparam int MB = 4;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } txn_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dm_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    dm_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [DW-1:0] mem     [0:4095];
    logic [DW-1:0] ref_mem [0:4095];

    always @(negedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr[11:0]] <= bus.mem_wdata;
        if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr[11:0]];
    end

    txn_t q0[$];
    txn_t q1[$];
    int   hist[$];   // one entry per cycle: granted port, -1 when idle
    int   gseq[$];   // grant log of the current scenario
    int   checks   = 0;
    int   errors   = 0;
    int   idle_pct = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Which port should win given the requests and the grant history.
    function automatic int ref_winner(bit r0, bit r1);
`ifdef DM_ARB_FAIRNESS_EN
        int last;
        int prev;
        int streak;
`endif
        if (!r0 && !r1) return -1;
`ifdef DM_ARB_FAIRNESS_EN
        if (r0 != r1) return r0 ? 0 : 1;
        last = (hist.size() > 0) ? hist[hist.size()-1] : -1;
        if (last < 0) begin
            prev = 1;
            foreach (hist[i]) if (hist[i] >= 0) prev = hist[i];
            return 1 - prev;
        end
        streak = 0;
        for (int i = hist.size() - 1; i >= 0 && hist[i] == last; i--) streak++;
        return (streak >= MB) ? 1 - last : last;
`else
        return r0 ? 0 : 1;
`endif
    endfunction

    function automatic txn_t rand_txn(bit rd_only);
        txn_t t;
        t.we    = rd_only ? 1'b0 : 1'($urandom_range(1));
        t.addr  = 16'h0200 + 16'($urandom_range(31));
        t.wdata = 16'($urandom);
        return t;
    endfunction

    // Requester p puts its next transaction on the bus (or drops req).
    task automatic present(int p);
        txn_t t;
        if (p == 0) begin
            if (q0.size() > 0 && $urandom_range(99) >= idle_pct) begin
                t = q0[0];
                bus.req0 = 1'b1; bus.we0 = t.we; bus.addr0 = t.addr; bus.wdata0 = t.wdata;
            end else begin
                bus.req0 = 1'b0;
            end
        end else begin
            if (q1.size() > 0 && $urandom_range(99) >= idle_pct) begin
                t = q1[0];
                bus.req1 = 1'b1; bus.we1 = t.we; bus.addr1 = t.addr; bus.wdata1 = t.wdata;
            end else begin
                bus.req1 = 1'b0;
            end
        end
    endtask

    // One clock: predict, step, compare, let requesters move on.
    task automatic cycle();
        int            w;
        txn_t          t;
        bit            rd;
        logic [DW-1:0] er;
        w  = ref_winner(bus.req0, bus.req1);
        rd = 1'b0;
        er = '0;
        t  = '0;
        hist.push_back(w);
        gseq.push_back(w);
        if (w >= 0) begin
            t = (w == 0) ? q0.pop_front() : q1.pop_front();
            if (t.we) ref_mem[t.addr[11:0]] = t.wdata;
            else begin rd = 1'b1; er = ref_mem[t.addr[11:0]]; end
        end
        @(posedge clk); #1;
        chk("gnt0",    bus.gnt0,    w == 0);
        chk("gnt1",    bus.gnt1,    w == 1);
        chk("rvalid0", bus.rvalid0, w == 0 && rd);
        chk("rvalid1", bus.rvalid1, w == 1 && rd);
        chk("mem_re",  bus.mem_re,  rd);
        chk("mem_we",  bus.mem_we,  w >= 0 && !rd);
        if (w >= 0) begin
            chk("mem_addr", bus.mem_addr, t.addr);
            if (!rd) chk("mem_wdata", bus.mem_wdata, t.wdata);
            $display("txn t=%0t port=%0d %s addr=%h data=%h", $time, w, rd ? "RD" : "WR",
                     t.addr, rd ? er : t.wdata);
        end
        if (w == 0 || !bus.req0) present(0);
        if (w == 1 || !bus.req1) present(1);
        @(negedge clk); #1;
        if (rd) chk("rd_data", bus.rd_data, er);
    endtask

    task automatic run(int budget);
        int n = 0;
        if (!bus.req0) present(0);
        if (!bus.req1) present(1);
        while ((q0.size() > 0 || q1.size() > 0) && n < budget) begin
            cycle();
            n++;
        end
        chk("drained", q0.size() + q1.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        q0.delete(); q1.delete(); hist.delete(); gseq.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t t;
        rst = 1'b1;
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
        for (int i = 0; i < 4096; i++) begin mem[i] = '0; ref_mem[i] = '0; end

        // Reset state
        @(posedge clk); #1;
        chk("rst_gnt0", bus.gnt0, 0);      chk("rst_gnt1", bus.gnt1, 0);
        chk("rst_rvalid0", bus.rvalid0, 0); chk("rst_rvalid1", bus.rvalid1, 0);
        chk("rst_mem_re", bus.mem_re, 0);  chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0); chk("rst_mem_wdata", bus.mem_wdata, 0);
        do_reset();

        // Write then read back on port 0
        t = '{we: 1'b1, addr: 16'h0010, wdata: 16'h1234}; q0.push_back(t);
        t = '{we: 1'b0, addr: 16'h0010, wdata: 16'h0000}; q0.push_back(t);
        run(20);
        chk("wr_rd_g0", gseq[0], 0);
        chk("wr_rd_g1", gseq[1], 0);

        // Both ports streaming reads
        do_reset();
        for (int i = 0; i < 16; i++) begin q0.push_back(rand_txn(1)); q1.push_back(rand_txn(1)); end
        run(100);
        chk("stream_len", gseq.size(), 32);
        for (int i = 0; i < 32 && i < gseq.size(); i++) begin
`ifdef DM_ARB_FAIRNESS_EN
            chk($sformatf("stream_g%0d", i), gseq[i], (i / 4) % 2);
`else
            chk($sformatf("stream_g%0d", i), gseq[i], (i < 16) ? 0 : 1);
`endif
        end

        // Port 1 alone: ten back-to-back writes, then port 0 reads them back
        do_reset();
        for (int i = 0; i < 10; i++) begin
            t = '{we: 1'b1, addr: 16'h0100 + 16'(i), wdata: 16'($urandom)};
            q1.push_back(t);
        end
        run(40);
        chk("burst_len", gseq.size(), 10);
        for (int i = 0; i < 10 && i < gseq.size(); i++) chk($sformatf("burst_g%0d", i), gseq[i], 1);
        for (int i = 0; i < 10; i++) begin
            t = '{we: 1'b0, addr: 16'h0100 + 16'(i), wdata: 16'h0000};
            q0.push_back(t);
        end
        run(40);

        // From IDLE after port 0 was served last
        do_reset();
        t = '{we: 1'b1, addr: 16'h0020, wdata: 16'hBEEF}; q0.push_back(t);
        run(10);
        cycle();
        t = '{we: 1'b0, addr: 16'h0020, wdata: 16'h0000}; q0.push_back(t);
        t = '{we: 1'b0, addr: 16'h0010, wdata: 16'h0000}; q1.push_back(t);
        gseq.delete();
        run(10);
`ifdef DM_ARB_FAIRNESS_EN
        chk("idle_first", gseq[0], 1);
`else
        chk("idle_first", gseq[0], 0);
`endif

        // Reset in the middle of a read
        do_reset();
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 16'h0010;
        @(posedge clk); #1;
        chk("mid_gnt0_before", bus.gnt0, 1);
        chk("mid_rvalid0_before", bus.rvalid0, 1);
        bus.req0 = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mid_gnt0", bus.gnt0, 0);       chk("mid_rvalid0", bus.rvalid0, 0);
        chk("mid_mem_re", bus.mem_re, 0);   chk("mid_mem_addr", bus.mem_addr, 0);
        @(posedge clk); #1;
        chk("mid_rvalid0_hold", bus.rvalid0, 0);
        @(negedge clk);
        rst = 1'b0;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 16'h0010;
        @(posedge clk); #1;
        chk("mid_after_gnt1", bus.gnt1, 1);
        chk("mid_after_rvalid1", bus.rvalid1, 1);
        bus.req1 = 1'b0;
        @(negedge clk); #1;
        chk("mid_after_rdata", bus.rd_data, 16'h1234);

        // Randomized traffic with idle gaps
        do_reset();
        idle_pct = 30;
        for (int i = 0; i < 60; i++) begin q0.push_back(rand_txn(0)); q1.push_back(rand_txn(0)); end
        run(2000);
        idle_pct = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
